weapon_controller: RTL and testbench

WEAPON_CONTROLLER -- requirements
Module: weapon_controller

---
 rtl/weapon_controller_if.sv | 23 ++
 rtl/weapon_controller.sv | 152 +++++++++++++++
 tb/tb_weapon_controller.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/weapon_controller_if.sv
// rtl/weapon_controller_if.sv - key inputs, weapon select and shot/aim outputs of weapon_controller
interface weapon_controller_if;
  logic        key_cw_n;
  logic        key_ccw_n;
  logic        key_fire_n;
  logic [1:0]  sw_type;
  logic        outgoing_projectiles;
  logic [3:0]  hit_angle;
  logic [1:0]  shootingtype;
  logic        busy;
  logic [1:0]  beam_left;
  logic [15:0] shot_count;

  modport master (
    output key_cw_n, key_ccw_n, key_fire_n, sw_type,
    input  outgoing_projectiles, hit_angle, shootingtype, busy, beam_left, shot_count
  );

  modport slave (
    input  key_cw_n, key_ccw_n, key_fire_n, sw_type,
    output outgoing_projectiles, hit_angle, shootingtype, busy, beam_left, shot_count
  );
endinterface

// File: rtl/weapon_controller.sv
// rtl/weapon_controller.sv - debounced aim/fire keys driving an IDLE/FIRE/COOLDOWN shot FSM
// SHOT_COOLDOWN_EN defined: COOLDOWN_CYCLES-long cooldown after each shot; undefined: FIRE returns to IDLE.
module weapon_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
  parameter int unsigned COOLDOWN_CYCLES = 12500000,
  parameter int unsigned BEAM_CHARGES    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  weapon_controller_if.slave    bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, FIRE, COOLDOWN} state_t;

  state_t state_q, state_d;

  // key bit order everywhere: [0] cw, [1] ccw, [2] fire
  logic [2:0]            sync1_q, sync1_d;
  logic [2:0]            sync2_q, sync2_d;
  logic [2:0]            level_q, level_d;
  logic [2:0]            prev_q, prev_d;
  logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [2:0]            strobe;

  logic [3:0]  angle_q, angle_d;
  logic [1:0]  stype_q, stype_d;
  logic [1:0]  beam_q, beam_d;
  logic [15:0] shots_q, shots_d;
  logic        fire_ok;
  logic        take_shot;

  always_comb begin
    sync1_d = {bus.key_fire_n, bus.key_ccw_n, bus.key_cw_n};
    sync2_d = sync1_q;
    prev_d  = level_q;
    for (int i = 0; i < 3; i++) begin
      level_d[i]  = level_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign strobe    = prev_q & ~level_q;
  assign fire_ok   = strobe[2] && (bus.sw_type != 2'b00) &&
                     ((bus.sw_type != 2'b11) || (beam_q != 2'd0));
  assign take_shot = (state_q == IDLE) && fire_ok;

`ifdef SHOT_COOLDOWN_EN
  localparam int CD_W = $clog2(COOLDOWN_CYCLES + 1);
  logic [CD_W-1:0] cd_cnt_q, cd_cnt_d;
  logic            cd_done;

  assign cd_done = (cd_cnt_q == CD_W'(COOLDOWN_CYCLES - 1));

  always_comb begin
    cd_cnt_d = '0;
    if (state_q == COOLDOWN && !cd_done) begin
      cd_cnt_d = cd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cd_cnt_q <= '0;
    end else begin
      cd_cnt_q <= cd_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fire_ok) state_d = FIRE;
      end
`ifdef SHOT_COOLDOWN_EN
      FIRE:     state_d = COOLDOWN;
      COOLDOWN: if (cd_done) state_d = IDLE;
`else
      FIRE:     state_d = IDLE;
      COOLDOWN: state_d = IDLE;
`endif
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.outgoing_projectiles = (state_q == FIRE);
    bus.busy                 = (state_q != IDLE);
    bus.hit_angle            = angle_q;
    bus.shootingtype         = stype_q;
    bus.beam_left            = beam_q;
    bus.shot_count           = shots_q;
  end

  // simultaneous cw and ccw strobes cancel
  always_comb begin
    angle_d = angle_q;
    if (strobe[0] && !strobe[1]) angle_d = angle_q + 4'd1;
    else if (strobe[1] && !strobe[0]) angle_d = angle_q - 4'd1;
    stype_d = stype_q;
    beam_d  = beam_q;
    shots_d = shots_q;
    if (take_shot) begin
      stype_d = bus.sw_type;
      shots_d = shots_q + 16'd1;
      if (bus.sw_type == 2'b11) beam_d = beam_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      level_q  <= '1;
      prev_q   <= '1;
      db_cnt_q <= '0;
      angle_q  <= '0;
      stype_q  <= '0;
      beam_q   <= 2'(BEAM_CHARGES);
      shots_q  <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      level_q  <= level_d;
      prev_q   <= prev_d;
      db_cnt_q <= db_cnt_d;
      angle_q  <= angle_d;
      stype_q  <= stype_d;
      beam_q   <= beam_d;
      shots_q  <= shots_d;
    end
  end

endmodule

// File: tb/tb_weapon_controller.sv
// tb/tb_weapon_controller.sv - randomized key stimulus checked against an edge-history reference model
module tb_weapon_controller;

  localparam int DB   = 4;
  localparam int CD   = 10;
  localparam int BEAM = 3;
`ifdef SHOT_COOLDOWN_EN
  localparam int HOLD_BUSY = CD;
`else
  localparam int HOLD_BUSY = 0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  weapon_controller_if bus();

  weapon_controller #(
    .DEBOUNCE_CYCLES(DB),
    .COOLDOWN_CYCLES(CD),
    .BEAM_CHARGES(BEAM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_vec   = 0;
  int n_bad   = 0;
  int edge_no = 0;

  // model state: raw key samples per edge, accepted levels, pending strobes
  logic [DB+1:0] hist [3];
  logic [2:0]    m_lvl;
  logic [2:0]    m_strb;
  int            m_angle, m_stype, m_beam, m_shots, busy_until;
  bit            m_pulse;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  task automatic drive(input logic [2:0] mask);
    bus.key_cw_n   = ~mask[0];
    bus.key_ccw_n  = ~mask[1];
    bus.key_fire_n = ~mask[2];
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) hist[k] = '1;
    m_lvl      = '1;
    m_strb     = '0;
    m_angle    = 0;
    m_stype    = 0;
    m_beam     = BEAM;
    m_shots    = 0;
    m_pulse    = 1'b0;
    busy_until = edge_no - 100;
  endtask

  task automatic compare_all();
    check("pulse", 16'(bus.outgoing_projectiles), 16'(m_pulse));
    check("busy", 16'(bus.busy), 16'(edge_no <= busy_until));
    check("hit_angle", 16'(bus.hit_angle), 16'(m_angle));
    check("shootingtype", 16'(bus.shootingtype), 16'(m_stype));
    check("beam_left", 16'(bus.beam_left), 16'(m_beam));
    check("shot_count", bus.shot_count, 16'(m_shots));
  endtask

  task automatic step();
    logic [2:0] raw;
    logic       new_lvl;
    bit         stable;
    @(posedge clk);
    edge_no++;
    raw = {bus.key_fire_n, bus.key_ccw_n, bus.key_cw_n};
    m_pulse = 1'b0;
    // strobes seen during the previous cycle act on this edge
    if (m_strb[0] != m_strb[1]) m_angle = (m_angle + (m_strb[0] ? 1 : 15)) % 16;
    if (m_strb[2] && (edge_no - 1 > busy_until) && bus.sw_type != 2'b00 &&
        !(bus.sw_type == 2'b11 && m_beam == 0)) begin
      m_pulse    = 1'b1;
      m_stype    = int'(bus.sw_type);
      if (bus.sw_type == 2'b11) m_beam--;
      m_shots    = (m_shots + 1) % 65536;
      busy_until = edge_no + HOLD_BUSY;
    end
    // a level is accepted once the 2-edge-delayed raw sample has disagreed for DB edges
    for (int k = 0; k < 3; k++) begin
      hist[k] = {hist[k][DB:0], raw[k]};
      stable  = 1'b1;
      for (int j = 2; j <= DB + 1; j++) if (hist[k][j] == m_lvl[k]) stable = 1'b0;
      new_lvl   = stable ? ~m_lvl[k] : m_lvl[k];
      m_strb[k] = m_lvl[k] & ~new_lvl;
      m_lvl[k]  = new_lvl;
    end
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    repeat (cycles) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;
  endtask

  task automatic press(input logic [2:0] mask, input int hold, input int gap);
    drive(mask);
    repeat (hold) step();
    drive(3'b000);
    repeat (gap) step();
  endtask

  initial begin
    reset       = 1'b1;
    bus.sw_type = 2'b00;
    drive(3'b000);
    #2;
    do_reset(3);

    repeat (3) press(3'b001, 6, 6);
    check("angle_after_3cw", 16'(bus.hit_angle), 16'd3);
    do_reset(2);
    press(3'b010, 6, 6);
    check("angle_ccw_wrap", 16'(bus.hit_angle), 16'd15);

    bus.sw_type = 2'b01;
    press(3'b100, 6, 14);
    check("shots_first", bus.shot_count, 16'd1);
    press(3'b100, 6, 0);
    press(3'b100, 6, 14);
    press(3'b100, 6, 14);

    bus.sw_type = 2'b11;
    repeat (4) press(3'b100, 6, 14);
    check("beam_exhausted", 16'(bus.beam_left), 16'd0);

    bus.sw_type = 2'b10;
    for (int i = 0; i < 10; i++) begin
      drive(i % 2 == 0 ? 3'b100 : 3'b000);
      repeat (2) step();
    end
    press(3'b100, 8, 14);
    bus.sw_type = 2'b00;
    press(3'b100, 6, 14);

    bus.sw_type = 2'b01;
    press(3'b101, 8, 0);
    repeat (3) step();
    do_reset(2);
    press(3'b100, 6, 14);

    for (int op = 0; op < 200; op++) begin
      bus.sw_type = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: press(3'($urandom_range(1, 7)), $urandom_range(1, 3), $urandom_range(1, 8));
        1: begin
          for (int i = 0; i < 6; i++) begin
            drive(3'($urandom_range(0, 7)));
            repeat ($urandom_range(1, 3)) step();
          end
          press(3'b000, 0, 8);
        end
        2: if ($urandom_range(0, 3) == 0) do_reset($urandom_range(1, 3));
        3: press(3'b011, $urandom_range(5, 9), $urandom_range(5, 10));
        default: press(3'($urandom_range(1, 7)), $urandom_range(5, 10), $urandom_range(0, 14));
      endcase
    end
    drive(3'b000);
    repeat (12) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
